// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: opcodes, FSM state codes and datapath select codes shared by control and datapath
package rv_ctrl_pkg;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;
  localparam logic [1:0] RS_ALUOUT = 2'b00;
  localparam logic [1:0] RS_DATA   = 2'b01;
  localparam logic [1:0] RS_ALURES = 2'b10;
  localparam logic [1:0] SA_PC    = 2'b00;
  localparam logic [1:0] SA_OLDPC = 2'b01;
  localparam logic [1:0] SA_A     = 2'b10;
  localparam logic [1:0] SB_RD2  = 2'b00;
  localparam logic [1:0] SB_IMM  = 2'b01;
  localparam logic [1:0] SB_FOUR = 2'b10;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
endpackage

// File: rtl/rv_alu_decoder.sv
// rv_alu_decoder: maps alu_op and instruction fields to the ALU operation code
module rv_alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);
  // alu_op 00/01 force add/sub; otherwise funct3 selects, with sub only for R-type funct7b5
  always_comb begin
    alu_control = !alu_op[1] ? (alu_op[0] ? ALU_SUB : ALU_ADD) :
                  funct3 == 3'b000 ? ((op5 & funct7b5) ? ALU_SUB : ALU_ADD) :
                  funct3 == 3'b010 ? ALU_SLT :
                  funct3 == 3'b110 ? ALU_OR :
                  funct3 == 3'b111 ? ALU_AND : ALU_ADD;
  end
endmodule

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: Moore FSM sequencing the multicycle RV32I datapath
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       illegal
);
  logic [3:0] r_state;
  logic [3:0] w_state;
  logic [3:0] w_next;
  logic [3:0] w_dec;
  logic [1:0] w_alu_op;
  logic       w_pc_update;
  logic       w_branch;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_legal;
  // while reset is high the selects already show FETCH, whatever the stale state
  assign w_state = reset ? S_FETCH : r_state;
  assign w_legal = op == OP_LW || op == OP_SW || op == OP_R || op == OP_I || op == OP_JAL || op == OP_BEQ;
  assign w_dec = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                 op == OP_R   ? S_EXECUTER :
                 op == OP_I   ? S_EXECUTEI :
                 op == OP_JAL ? S_JAL :
                 op == OP_BEQ ? S_BEQ : S_FETCH;
  // next-state selection
  always_comb begin
    w_next = r_state == S_FETCH ? S_DECODE :
             r_state == S_DECODE ? w_dec :
             r_state == S_MEMADR ? (op[5] ? S_MEMWRITE : S_MEMREAD) :
             r_state == S_MEMREAD ? S_MEMWB :
             (r_state == S_EXECUTER || r_state == S_EXECUTEI || r_state == S_JAL) ? S_ALUWB : S_FETCH;
  end
  // state register
  always_ff @(posedge clk) begin
    r_state <= reset ? S_FETCH : w_next;
  end
  // per-state Moore outputs
  always_comb begin
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    w_alu_op    = 2'b00;
    adr_src     = 1'b0;
    result_src  = RS_ALUOUT;
    alu_src_a   = SA_PC;
    alu_src_b   = SB_RD2;
    case (w_state)
      S_FETCH: begin
        w_ir_write  = 1'b1;
        w_pc_update = 1'b1;
        alu_src_b   = SB_FOUR;
        result_src  = RS_ALURES;
      end
      S_DECODE: begin
        alu_src_a = SA_OLDPC;
        alu_src_b = SB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SA_A;
        alu_src_b = SB_IMM;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src  = RS_DATA;
        w_reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = SA_A;
        w_alu_op  = 2'b10;
      end
      S_EXECUTEI: begin
        alu_src_a = SA_A;
        alu_src_b = SB_IMM;
        w_alu_op  = 2'b10;
      end
      S_ALUWB: w_reg_write = 1'b1;
      S_JAL: begin
        alu_src_a   = SA_OLDPC;
        alu_src_b   = SB_FOUR;
        w_pc_update = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = SA_A;
        w_alu_op  = 2'b01;
        w_branch  = 1'b1;
      end
      default: ;
    endcase
  end
  assign pc_write  = ~reset & (w_pc_update | (w_branch & zero));
  assign ir_write  = ~reset & w_ir_write;
  assign mem_write = ~reset & w_mem_write;
  assign reg_write = ~reset & w_reg_write;
  assign illegal   = ~reset & (w_state == S_DECODE) & ~w_legal;
  assign imm_src = op == OP_SW ? IMM_S : op == OP_BEQ ? IMM_B : op == OP_JAL ? IMM_J : IMM_I;
  rv_alu_decoder u_alu_dec (
    .alu_op     (w_alu_op),
    .op5        (op[5]),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .alu_control(alu_control)
  );
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb_rv_multicycle_ctrl: table-driven per-cycle checks plus instruction-length and reset sequences
module tb_rv_multicycle_ctrl;
  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] IA  = 7'b0010011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;
  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic [16:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic reset, funct7b5, zero;
  logic [6:0] op;
  logic [2:0] funct3;
  logic pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [16:0] got;
  int n_chk = 0;
  int n_fail = 0;
  vec_t tv[$];
  rv_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .illegal(illegal)
  );
  always #5 clk = ~clk;
  assign got = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a, alu_src_b, alu_control, imm_src, illegal};
  // wr = {pc_write, adr_src, mem_write, ir_write, reg_write}
  function automatic vec_t v(logic rst, logic [6:0] o, logic [2:0] f3, logic f7, logic z,
                             logic [4:0] wr, logic [1:0] rs, logic [1:0] sa, logic [1:0] sb,
                             logic [2:0] ac, logic [1:0] imm, logic ill);
    vec_t t;
    t.rst = rst; t.op = o; t.f3 = f3; t.f7 = f7; t.z = z;
    t.exp = {wr, rs, sa, sb, ac, imm, ill};
    return t;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  task automatic drive(logic rst, logic [6:0] o, logic [2:0] f3, logic f7, logic z);
    reset = rst; op = o; funct3 = f3; funct7b5 = f7; zero = z;
  endtask
  // runs one instruction from FETCH to the next FETCH, counting cycles and write pulses
  task automatic cpi(string name, logic [6:0] o, logic [2:0] f3, logic f7, logic z,
                     int ecyc, int erw, int emw);
    int n = 0;
    int rws = 0;
    int mws = 0;
    drive(1'b0, o, f3, f7, z);
    do begin
      #1;
      rws += int'(reg_write);
      mws += int'(mem_write);
      n++;
      @(posedge clk);
      #1;
    end while (!ir_write && n < 10);
    chk({name, " cycles"}, n, ecyc);
    chk({name, " reg_write pulses"}, rws, erw);
    chk({name, " mem_write pulses"}, mws, emw);
  endtask
  initial begin
    tv.push_back(v(1, R, 3'b000, 1, 0, 5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0));
    tv.push_back(v(1, R, 3'b000, 1, 0, 5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0));
    tv.push_back(v(0, R, 3'b000, 1, 0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0));
    tv.push_back(v(0, R, 3'b000, 1, 0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0));
    tv.push_back(v(0, R, 3'b000, 1, 0, 5'b00000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 0));
    tv.push_back(v(0, R, 3'b000, 1, 0, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0));
    tv.push_back(v(0, R, 3'b110, 0, 0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0));
    tv.push_back(v(0, R, 3'b110, 0, 0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0));
    tv.push_back(v(0, R, 3'b110, 0, 0, 5'b00000, 2'b00, 2'b10, 2'b00, 3'b011, 2'b00, 0));
    tv.push_back(v(0, R, 3'b110, 0, 0, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0));
    tv.push_back(v(0, R, 3'b010, 0, 0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0));
    tv.push_back(v(0, R, 3'b010, 0, 0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0));
    tv.push_back(v(0, R, 3'b010, 0, 0, 5'b00000, 2'b00, 2'b10, 2'b00, 3'b101, 2'b00, 0));
    tv.push_back(v(0, R, 3'b010, 0, 0, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0));
    tv.push_back(v(0, LW, 3'b010, 0, 0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0));
    tv.push_back(v(0, LW, 3'b010, 0, 0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0));
    tv.push_back(v(0, LW, 3'b010, 0, 0, 5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0));
    tv.push_back(v(0, LW, 3'b010, 0, 0, 5'b01000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0));
    tv.push_back(v(0, LW, 3'b010, 0, 0, 5'b00001, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 0));
    tv.push_back(v(0, SW, 3'b010, 0, 0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01, 0));
    tv.push_back(v(0, SW, 3'b010, 0, 0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b01, 0));
    tv.push_back(v(0, SW, 3'b010, 0, 0, 5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0));
    tv.push_back(v(0, SW, 3'b010, 0, 0, 5'b01100, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0));
    tv.push_back(v(0, IA, 3'b000, 1, 0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0));
    tv.push_back(v(0, IA, 3'b000, 1, 0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0));
    tv.push_back(v(0, IA, 3'b000, 1, 0, 5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0));
    tv.push_back(v(0, IA, 3'b000, 1, 0, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0));
    tv.push_back(v(0, IA, 3'b111, 0, 0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0));
    tv.push_back(v(0, IA, 3'b111, 0, 0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0));
    tv.push_back(v(0, IA, 3'b111, 0, 0, 5'b00000, 2'b00, 2'b10, 2'b01, 3'b010, 2'b00, 0));
    tv.push_back(v(0, IA, 3'b111, 0, 0, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0));
    tv.push_back(v(0, JAL, 3'b000, 0, 0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b11, 0));
    tv.push_back(v(0, JAL, 3'b000, 0, 0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b11, 0));
    tv.push_back(v(0, JAL, 3'b000, 0, 0, 5'b10000, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 0));
    tv.push_back(v(0, JAL, 3'b000, 0, 0, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b11, 0));
    tv.push_back(v(0, BEQ, 3'b000, 0, 1, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b10, 0));
    tv.push_back(v(0, BEQ, 3'b000, 0, 1, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10, 0));
    tv.push_back(v(0, BEQ, 3'b000, 0, 1, 5'b10000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0));
    tv.push_back(v(0, BEQ, 3'b000, 0, 0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b10, 0));
    tv.push_back(v(0, BEQ, 3'b000, 0, 0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10, 0));
    tv.push_back(v(0, BEQ, 3'b000, 0, 0, 5'b00000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0));
    tv.push_back(v(0, BAD, 3'b000, 0, 0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0));
    tv.push_back(v(0, BAD, 3'b000, 0, 0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 1));
    tv.push_back(v(0, R, 3'b001, 0, 0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0));
    tv.push_back(v(0, R, 3'b001, 0, 0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0));
    tv.push_back(v(0, R, 3'b001, 0, 0, 5'b00000, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00, 0));
    tv.push_back(v(0, R, 3'b001, 0, 0, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0));
    tv.push_back(v(0, LW, 3'b010, 0, 0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0));
    tv.push_back(v(0, LW, 3'b010, 0, 0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0));
    tv.push_back(v(0, LW, 3'b010, 0, 0, 5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0));
    tv.push_back(v(1, LW, 3'b010, 0, 0, 5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0));
    tv.push_back(v(0, LW, 3'b010, 0, 0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0));
    tv.push_back(v(0, LW, 3'b010, 0, 0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0));
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].rst, tv[i].op, tv[i].f3, tv[i].f7, tv[i].z);
      #1;
      chk($sformatf("vec%0d", i), 32'(got), 32'(tv[i].exp));
      @(posedge clk);
      #1;
    end
    drive(1'b1, R, 3'b000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    cpi("R-type", R, 3'b000, 1'b1, 1'b0, 4, 1, 0);
    cpi("I-ALU", IA, 3'b000, 1'b0, 1'b0, 4, 1, 0);
    cpi("lw", LW, 3'b010, 1'b0, 1'b0, 5, 1, 0);
    cpi("sw", SW, 3'b010, 1'b0, 1'b0, 4, 0, 1);
    cpi("jal", JAL, 3'b000, 1'b0, 1'b0, 4, 1, 0);
    cpi("beq", BEQ, 3'b000, 1'b0, 1'b1, 3, 0, 0);
    cpi("illegal", BAD, 3'b000, 1'b0, 1'b0, 2, 0, 0);
    drive(1'b0, LW, 3'b010, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("memread adr_src", 32'(adr_src), 32'd1);
    reset = 1'b1;
    #1;
    chk("reset-in-memread writes", 32'({reg_write, mem_write, ir_write, pc_write}), 32'd0);
    chk("reset-in-memread result_src", 32'(result_src), 32'd2);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("after reset fetch ir_write", 32'(ir_write), 32'd1);
    chk("after reset reg_write", 32'(reg_write), 32'd0);
    @(posedge clk);
    #2;
    chk("after reset decode srcA", 32'(alu_src_a), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
